// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and helpers for the UART TX arbitrating serializer
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_HDR,
    ST_DATA
  } tx_arb_state_e;

  localparam int HDR_CH_W = 4;

  // Channel index occupies the low nibble; the base supplies the upper bits.
  function automatic logic [7:0] hdr_byte(input logic [7:0] base, input logic [HDR_CH_W-1:0] ch);
    return base | {{(8-HDR_CH_W){1'b0}}, ch};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from last_grant+1
module rr_arbiter #(
  parameter int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  input  logic         en,
  output logic [W-1:0] grant,
  output logic         valid
);

  logic [W-1:0] idx;

  // Walk from the farthest candidate back to the nearest so the nearest one wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(last_grant) + k) % N);
      if (en && req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb_serializer.sv
// rtl/uart_tx_arb_serializer.sv - round-robin drain of reply FIFOs into the byte-wide UART TX stream
module uart_tx_arb_serializer
  import uart_tx_pkg::*;
#(
  parameter int           NUM_CH     = 2,
  parameter int           WORD_BYTES = 2,
  parameter bit           HDR_EN     = 1'b1,
  parameter logic [7:0]   HDR_BASE   = 8'hA0,
  localparam int          CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int          FW         = 8 * WORD_BYTES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    fifo_empty,
  output logic [NUM_CH-1:0]    fifo_rd_en,
  input  logic [NUM_CH*FW-1:0] fifo_rd_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [CW-1:0]        active_ch
);

  localparam int BW = $clog2(WORD_BYTES + 1);

  tx_arb_state_e       state;
  logic [CW-1:0]       ch;
  logic [CW-1:0]       last_ch;
  logic [FW-1:0]       shift;
  logic [BW-1:0]       byte_cnt;
  logic [CW-1:0]       gnt;
  logic                gnt_valid;
  logic [FW-1:0]       rd_word;
  logic [HDR_CH_W-1:0] ch_hdr;

  assign rd_word   = fifo_rd_data[int'(ch)*FW +: FW];
  assign ch_hdr    = HDR_CH_W'(ch);
  assign active_ch = ch;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req        (~fifo_empty),
    .last_grant (last_ch),
    .en         (state == ST_IDLE),
    .grant      (gnt),
    .valid      (gnt_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ch         <= '0;
      last_ch    <= CW'(NUM_CH - 1);
      shift      <= '0;
      byte_cnt   <= '0;
      fifo_rd_en <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            ch         <= gnt;
            fifo_rd_en <= NUM_CH'(1) << gnt;
            busy       <= 1'b1;
            state      <= ST_POP;
          end
        end
        ST_POP: begin
          fifo_rd_en <= '0;
          state      <= ST_LOAD;
        end
        ST_LOAD: begin
          // FIFO data arrives one cycle after the pop, so it is captured here.
          byte_cnt <= '0;
          tx_valid <= 1'b1;
          if (HDR_EN) begin
            shift   <= rd_word;
            tx_data <= hdr_byte(HDR_BASE, ch_hdr);
            state   <= ST_HDR;
          end else begin
            shift   <= rd_word >> 8;
            tx_data <= rd_word[7:0];
            state   <= ST_DATA;
          end
        end
        ST_HDR: begin
          if (tx_ready) begin
            tx_data <= shift[7:0];
            shift   <= shift >> 8;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_ready) begin
            if (byte_cnt == BW'(WORD_BYTES - 1)) begin
              tx_valid <= 1'b0;
              tx_data  <= '0;
              last_ch  <= ch;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              tx_data  <= shift[7:0];
              shift    <= shift >> 8;
              byte_cnt <= byte_cnt + BW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
